// File: rtl/bcd_count_ctrl.sv
// Run/pause/done sequencer for an external 4-digit BCD counter, with registered control outputs.
// Optional build macro BCD_COUNT_CTRL_AUTORELOAD_EN: DONE lasts one cycle, clears and restarts.
module bcd_count_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_clear,
  input  logic [15:0] target,
  input  logic [15:0] q,
  output logic        cnt_tick,
  output logic        cnt_clr,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam logic [7:0] PresLast = 8'(PRESCALE - 1);

  state_e     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic       err_q, err_d;
  logic       tick_q, tick_d;
  logic       clr_q, clr_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       target_ok;
  logic       at_target;

  assign target_ok = (target[3:0] <= 4'd9) && (target[7:4] <= 4'd9) &&
                     (target[11:8] <= 4'd9) && (target[15:12] <= 4'd9);
  assign at_target = (q == target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      presc_q <= 8'd0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      err_q   <= err_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Priority: clear, then stop, then start; stop alongside start blocks the start.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    err_d   = err_q;
    if (cmd_clear) begin
      state_d = StIdle;
      presc_d = 8'd0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cmd_stop && cmd_start) begin
            if (target_ok) begin
              state_d = StRun;
              presc_d = 8'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (cmd_stop) begin
            state_d = StPause;
          end else if (at_target) begin
            state_d = StDone;
          end else if (presc_q == PresLast) begin
            presc_d = 8'd0;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        StPause: begin
          if (!cmd_stop && cmd_start) begin
            state_d = StRun;
          end
        end
        StDone: begin
`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
          state_d = StRun;
          presc_d = 8'd0;
`else
          state_d = StDone;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tick_d = !cmd_clear && !cmd_stop && (state_q == StRun) && !at_target &&
             (presc_q == PresLast);
    done_d = (state_d == StDone) && (state_q != StDone);
    busy_d = (state_d == StRun) || (state_d == StPause);
`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
    clr_d  = cmd_clear || done_d;
`else
    clr_d  = cmd_clear;
`endif
  end

  assign cnt_tick = tick_q;
  assign cnt_clr  = clr_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign state    = state_q;

endmodule
